// File: rtl/timer_responder.sv
// timer_responder: memory-mapped countdown timer (CTRL/PRESET/COUNT) with irq; ports clk, reset (sync, active-low), addr, we, wdata, rdata, irq
module timer_responder #(
    parameter int WIDTH  = 32,
    parameter int CTRL_W = 4
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [1:0]       addr,
    input  logic             we,
    input  logic [WIDTH-1:0] wdata,
    output logic [WIDTH-1:0] rdata,
    output logic             irq
);
    typedef enum logic [1:0] {IDLE, LOAD, CNT, INT} state_t;
    state_t            state;
    logic [CTRL_W-1:0] ctrl;
    logic [WIDTH-1:0]  preset, count;
    logic              flag, ctrl_wr;
    assign ctrl_wr = we && addr == 2'd0;
    assign irq     = flag & ctrl[3];
    always_comb begin
        rdata = addr == 2'd0 ? {{(WIDTH-CTRL_W){1'b0}}, ctrl} :
                addr == 2'd1 ? preset :
                addr == 2'd2 ? count : '0;
    end
    always_ff @(posedge clk) begin
        if (!reset) begin
            state  <= IDLE;
            ctrl   <= '0;
            preset <= '0;
            count  <= '0;
            flag   <= 1'b0;
        end else begin
            if (ctrl_wr) ctrl <= wdata[CTRL_W-1:0];
            if (we && addr == 2'd1) preset <= wdata;
            case (state)
                IDLE: if (ctrl[0]) state <= LOAD;
                LOAD: begin
                    count <= preset;
                    state <= CNT;
                end
                CNT: begin
                    if (!ctrl[0]) state <= IDLE;
                    else if (count > WIDTH'(1)) count <= count - WIDTH'(1);
                    else begin
                        count <= '0;
                        state <= INT;
                    end
                end
                INT: begin
                    if (ctrl[2:1] == 2'b01) state <= LOAD;
                    else begin
                        state <= IDLE;
                        if (!ctrl_wr) ctrl[0] <= 1'b0;
                    end
                end
                default: state <= IDLE;
            endcase
            flag <= ctrl_wr ? 1'b0 : state == INT ? 1'b1 : state == LOAD ? 1'b0 : flag;
        end
    end
endmodule

// File: tb/tb_timer_responder.sv
// tb_timer_responder: scoreboard bench for timer_responder
module tb_timer_responder;
    logic        clk = 1'b0, reset = 1'b0, we = 1'b0, irq;
    logic [1:0]  addr = 2'd0;
    logic [31:0] wdata = 32'd0, rdata;
    int          vectors = 0, miscompares = 0;
    string       q_tag[$];
    logic [1:0]  q_a[$];
    logic [31:0] q_v[$];
    logic        q_i[$];
    timer_responder #(.WIDTH(32), .CTRL_W(4)) dut (
        .clk(clk), .reset(reset), .addr(addr), .we(we),
        .wdata(wdata), .rdata(rdata), .irq(irq)
    );
    always #10 clk = ~clk;
    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        vectors++;
        if (got !== exp) begin
            miscompares++;
            $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
        end
    endtask
    task automatic tick(input logic w, input logic [1:0] a, input logic [31:0] d);
        @(negedge clk);
        we = w;
        addr = a;
        wdata = d;
        @(posedge clk);
        #1;
        we = 1'b0;
    endtask
    task automatic idle();
        tick(1'b0, 2'd0, 32'd0);
    endtask
    task automatic push(input string tag, input logic [1:0] a, input logic [31:0] v, input logic i);
        q_tag.push_back(tag);
        q_a.push_back(a);
        q_v.push_back(v);
        q_i.push_back(i);
    endtask
    task automatic drain();
        string       t;
        logic [31:0] v;
        logic        i;
        while (q_tag.size() > 0) begin
            t = q_tag.pop_front();
            addr = q_a.pop_front();
            v = q_v.pop_front();
            i = q_i.pop_front();
            #1;
            chk(t, rdata, v);
            chk({t, "_irq"}, {31'd0, irq}, {31'd0, i});
        end
    endtask
    initial begin
        #200000;
        $display("FAIL watchdog: got timeout, expected completion");
        $fatal(1, "watchdog expired");
    end
    initial begin
        tick(1'b1, 2'd1, 32'd5);
        tick(1'b1, 2'd1, 32'd5);
        push("rst_ctrl", 2'd0, 0, 0);
        push("rst_preset", 2'd1, 0, 0);
        push("rst_count", 2'd2, 0, 0);
        push("rst_unmapped", 2'd3, 0, 0);
        drain();
        reset = 1'b1;
        tick(1'b1, 2'd1, 32'd3);
        tick(1'b1, 2'd0, 32'h9);
        for (int k = 1; k <= 6; k++) begin
            idle();
            push("os_count", 2'd2, k < 2 ? 0 : k < 6 ? 5 - k : 0, k == 6);
            drain();
        end
        push("os_ctrl", 2'd0, 32'h8, 1'b1);
        drain();
        for (int k = 0; k < 3; k++) begin
            idle();
            push("os_sticky", 2'd0, 32'h8, 1'b1);
            drain();
        end
        tick(1'b1, 2'd0, 32'h0);
        push("os_clear", 2'd0, 0, 0);
        drain();
        tick(1'b1, 2'd1, 32'd2);
        tick(1'b1, 2'd0, 32'hB);
        for (int k = 1; k <= 22; k++) begin
            idle();
            push("ar_pulse", 2'd0, 32'hB, k >= 5 && (k - 5) % 4 == 0);
            drain();
        end
        tick(1'b1, 2'd0, 32'h0);
        idle();
        idle();
        push("ar_off", 2'd0, 0, 0);
        drain();
        tick(1'b1, 2'd1, 32'd10);
        tick(1'b1, 2'd0, 32'h9);
        for (int k = 0; k < 5; k++) idle();
        push("pz_seven", 2'd2, 7, 0);
        drain();
        tick(1'b1, 2'd0, 32'h8);
        push("pz_write", 2'd2, 6, 0);
        drain();
        for (int k = 0; k < 10; k++) begin
            idle();
            push("pz_hold", 2'd2, 6, 0);
            drain();
        end
        tick(1'b1, 2'd0, 32'h9);
        idle();
        push("pz_load", 2'd2, 6, 0);
        drain();
        idle();
        push("pz_reload", 2'd2, 10, 0);
        drain();
        idle();
        push("pz_dec", 2'd2, 9, 0);
        drain();
        tick(1'b1, 2'd1, 32'd4);
        push("pw_count", 2'd2, 8, 0);
        push("pw_preset", 2'd1, 4, 0);
        drain();
        tick(1'b1, 2'd0, 32'h0);
        idle();
        push("pz_stop", 2'd2, 7, 0);
        drain();
        tick(1'b1, 2'd1, 32'd1);
        tick(1'b1, 2'd0, 32'h1);
        for (int k = 0; k < 4; k++) idle();
        push("mk_expire", 2'd0, 0, 0);
        drain();
        tick(1'b1, 2'd0, 32'h8);
        push("mk_clear", 2'd0, 32'h8, 0);
        drain();
        tick(1'b1, 2'd0, 32'h9);
        for (int k = 0; k < 3; k++) idle();
        tick(1'b1, 2'd0, 32'hD);
        push("pr_ctrl", 2'd0, 32'hD, 0);
        drain();
        for (int k = 0; k < 4; k++) idle();
        push("pr_rerun", 2'd0, 32'hC, 1);
        drain();
        tick(1'b1, 2'd0, 32'h0);
        tick(1'b1, 2'd1, 32'd6);
        tick(1'b1, 2'd0, 32'h9);
        idle();
        idle();
        tick(1'b1, 2'd0, 32'h8);
        idle();
        tick(1'b1, 2'd2, 32'h55);
        push("ro_count", 2'd2, 5, 0);
        drain();
        tick(1'b1, 2'd3, 32'hAA);
        push("ro_count2", 2'd2, 5, 0);
        push("un_read", 2'd3, 0, 0);
        push("ro_preset", 2'd1, 6, 0);
        push("ro_ctrl", 2'd0, 32'h8, 0);
        drain();
        tick(1'b1, 2'd0, 32'h9);
        for (int k = 0; k < 4; k++) idle();
        push("rm_four", 2'd2, 4, 0);
        drain();
        reset = 1'b0;
        idle();
        push("rm_ctrl", 2'd0, 0, 0);
        push("rm_preset", 2'd1, 0, 0);
        push("rm_count", 2'd2, 0, 0);
        push("rm_unmapped", 2'd3, 0, 0);
        drain();
        reset = 1'b1;
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
